// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the fetch buffer.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN  = 32;
    localparam int unsigned FETCH_DEPTH = 2;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: circular buffer with push, pop, synchronous clear and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointers and count; clear wins over any simultaneous push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= next_ptr(tail_ptr);
            if (pop)  head_ptr <= next_ptr(head_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail_ptr] <= push_data;
    end

    assign head = mem[head_ptr];

    count_le_depth: assert property (@(posedge clk) disable iff (!reset_n) count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_buffer.sv
// Decoupling buffer between instruction fetch and decode: issue control, response pairing, flush.
// Optional FETCH_BUFFER_PERF_EN adds saturating stall_cnt / drop_cnt outputs.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = FETCH_XLEN,
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_F,
    output logic            stall_PC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            flush,
    output logic            valid_D,
    input  logic            ready_D,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D
`ifdef FETCH_BUFFER_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     drop_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic            inflight;
    logic [XLEN-1:0] cap_pc;
    logic [CW-1:0]   count;
    logic            pop;
    logic            push;
    logic            issue_ok;
    logic [OW-1:0]   occ;
    entry_t          push_data;
    entry_t          head;

    // Occupancy after this cycle's pop, counting the response still in flight.
    always_comb begin
        pop      = valid_D & ready_D;
        occ      = OW'(count) + OW'(inflight) - OW'(pop);
        issue_ok = occ < OW'(DEPTH);
    end

    assign imem_req  = reset_n & issue_ok & ~flush;
    assign stall_PC  = reset_n & ~issue_ok & ~flush;
    assign imem_addr = pc_F;
    assign push      = inflight & ~flush;
    assign push_data = '{pc: cap_pc, instr: imem_rdata};
    assign valid_D   = (count != '0);
    assign instr_D   = head.instr;
    assign pc_D      = head.pc;

    // Remember the PC of each request so it pairs with next cycle's read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            cap_pc   <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) cap_pc <= pc_F;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_BUFFER_PERF_EN
    logic [OW-1:0] drop_amt;
    logic [32:0]   drop_sum;

    // A head entry handed to decode under flush was consumed, not dropped.
    always_comb begin
        drop_amt = OW'(count) + OW'(inflight) - OW'(pop);
        drop_sum = {1'b0, drop_cnt} + 33'(drop_amt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (stall_PC && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'(1);
            if (flush) drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC and instruction.
REQ-002 SHALL have parameter DEPTH, default 2, entry count of the instruction queue; legal range 2..8.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pc_F  input  XLEN  current PC from the PC register.
REQ-007 stall_PC  output  1  holds the PC register when high.
REQ-008 imem_req  output  1  instruction memory read strobe.
REQ-009 imem_addr  output  XLEN  read address, equal to pc_F.
REQ-010 imem_rdata  input  XLEN  read data, valid exactly one cycle after imem_req.
REQ-011 flush  input  1  redirect (branch/jump taken); discards all fetched state.
REQ-012 valid_D  output  1  instr_D/pc_D hold a valid entry.
REQ-013 ready_D  input  1  decode accepts the head entry.
REQ-014 instr_D  output  XLEN  head instruction.
REQ-015 pc_D  output  XLEN  PC of head instruction.

Function
REQ-016 SHALL track count (entries queued, 0..DEPTH) and inflight (1 if a request issued last cycle and was not flushed).
REQ-017 pop = valid_D & ready_D; issue_ok = (count + inflight - pop) < DEPTH.
REQ-018 imem_req = issue_ok & ~flush; stall_PC = ~issue_ok & ~flush (combinational from ready_D and flush).
REQ-019 On a cycle with imem_req high, the PC of that request SHALL be captured so it pairs with imem_rdata next cycle.
REQ-020 When inflight is 1 and flush is low, {captured PC, imem_rdata} SHALL be pushed at the tail that edge.
REQ-021 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-022 Queue SHALL be FIFO; head/tail pointers wrap modulo DEPTH.
REQ-023 valid_D = (count != 0); instr_D/pc_D SHALL come from the head entry and be stable while valid_D & ~ready_D.
REQ-024 Fetch-to-decode latency SHALL be 2 cycles (request edge, push edge) with an empty queue; no bypass.
REQ-025 flush SHALL, at the next edge, set count=0, inflight=0, reset pointers, and drop the response arriving that cycle.
REQ-026 flush SHALL take priority over simultaneous push and pop; pop under flush is still a legal handshake at decode.
REQ-027 Overflow SHALL be impossible by construction; an assertion SHALL check count <= DEPTH.
REQ-028 Sustained throughput SHALL be 1 instruction/cycle while ready_D is held high.

Reset
REQ-029 While reset_n is low: count=0, inflight=0, pointers=0, valid_D=0, stall_PC=0, imem_req=0 (forced).
REQ-030 Deassertion SHALL allow imem_req on the first following cycle; queue data storage is not reset.

Configuration
REQ-031 Macro FETCH_BUFFER_PERF_EN SHALL add outputs stall_cnt[31:0] (cycles with stall_PC high) and drop_cnt[31:0] (entries plus inflight responses discarded by flush), both saturating, reset to 0.
REQ-032 Without FETCH_BUFFER_PERF_EN these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 Package fetch_pkg SHALL hold XLEN default, typedef fetch_entry_t {pc, instr}, and DEPTH default.
REQ-034 Storage SHALL be one sub-module, fetch_fifo (entries of fetch_entry_t, push/pop/clear, count).
REQ-035 fetch_buffer SHALL hold the inflight flag, captured PC, issue logic and perf counters.

Verification
REQ-036 Reset then ready_D=1, pc_F stepping 0x0,0x4,0x8: instr for 0x0 on valid_D at cycle 2, then one per cycle; stall_PC never high.
REQ-037 ready_D=0 from cycle 0: after 2 requests (0x0,0x4) stall_PC=1, count=2, pc_D=0x0 held; ready_D=1 releases at one entry/cycle in order.
REQ-038 count=2, inflight=0, flush=1 with ready_D=0: next cycle valid_D=0, stall_PC=0, imem_req=1.
REQ-039 flush in the cycle response for 0x8 returns: 0x8 never appears on pc_D; the next pc_D is the redirect target.
REQ-040 reset_n low mid-stream with count=1: valid_D=0 and imem_req=0 immediately, not at the clock edge.
REQ-041 With FETCH_BUFFER_PERF_EN: scenario REQ-037 gives stall_cnt equal to stalled cycles; REQ-038 gives drop_cnt=2.
